// File: rtl/dvs_aer_rx.sv
// dvs_aer_rx: DVS camera AER receiver. Synchronizes the 4-phase req/ack
// handshake into clk, packs {pol, y, x} into one word and writes it to the
// event FIFO, applying a drop-or-stall policy when the FIFO is full.
// Optional build macro: DVS_AER_DROP_COUNT_EN adds drop_clr / drop_count.
module dvs_aer_rx #(
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 8,
  parameter int unsigned DATA_W       = X_W + Y_W + 1,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DROP_ON_FULL = 1
`ifdef DVS_AER_DROP_COUNT_EN
  ,
  parameter int unsigned CNT_W        = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              aer_req,
  input  logic [X_W-1:0]    aer_x,
  input  logic [Y_W-1:0]    aer_y,
  input  logic              aer_pol,
  output logic              aer_ack,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_push,
  input  logic              fifo_full
`ifdef DVS_AER_DROP_COUNT_EN
  ,
  input  logic              drop_clr,
  output logic [CNT_W-1:0]  drop_count
`endif
);

  // One-hot encoding so aer_ack / fifo_push come straight off a single flop.
  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StStall = 4'b0010,
    StPush  = 4'b0100,
    StAck   = 4'b1000
  } state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   armed_q;
  logic                   req_s;

  assign req_s     = sync_q[SYNC_STAGES-1];
  assign fifo_push = state_q[2];
  assign aer_ack   = state_q[3];

  // Synchronize aer_req and arm once a genuine low has been observed.
  // fill_q marks when the chain holds real samples rather than reset zeros,
  // so a request held high across reset cannot arm the receiver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], aer_req};
      fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      armed_q <= armed_q | (fill_q[SYNC_STAGES-1] & ~req_s);
    end
  end

  // Handshake FSM, event capture and (optionally) the drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fifo_data  <= '0;
`ifdef DVS_AER_DROP_COUNT_EN
      drop_count <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_s && enable && armed_q) begin
            fifo_data <= {aer_pol, aer_y, aer_x};
            if (!fifo_full) begin
              state_q <= StPush;
            end else if (DROP_ON_FULL != 0) begin
              // Ack without pushing: the event is discarded.
              state_q <= StAck;
`ifdef DVS_AER_DROP_COUNT_EN
              if (drop_count != '1) drop_count <= drop_count + 1'b1;
`endif
            end else begin
              state_q <= StStall;
            end
          end
        end
        StStall: begin
          if (!fifo_full) state_q <= StPush;
        end
        StPush: begin
          state_q <= StAck;
        end
        StAck: begin
          if (!req_s) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
`ifdef DVS_AER_DROP_COUNT_EN
      // Clear overrides any increment in the same cycle.
      if (drop_clr) drop_count <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_dvs_aer_rx.sv
// Directed bench for dvs_aer_rx: one drop-on-full instance and one stalling
// instance share clock, reset, enable and event payload lines.
`timescale 1ns/1ps
module tb_dvs_aer_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [7:0]  aer_x = '0;
  logic [7:0]  aer_y = '0;
  logic        aer_pol = 1'b0;

  logic        req_d = 1'b0, ack_d, push_d, full_d = 1'b0;
  logic [16:0] data_d;
  logic        req_st = 1'b0, ack_s, push_s, full_s = 1'b0;
  logic [16:0] data_s;
`ifdef DVS_AER_DROP_COUNT_EN
  logic        drop_clr = 1'b0;
  logic [15:0] dc_d, dc_s;
`endif

  int tests = 0;
  int fails = 0;
  int pcount = 0;
  logic [16:0] pushq[$];

  always #5 clk = ~clk;

  dvs_aer_rx #(.DROP_ON_FULL(1)) u_drop (
    .clk(clk), .rst_n(rst_n), .enable(enable), .aer_req(req_d),
    .aer_x(aer_x), .aer_y(aer_y), .aer_pol(aer_pol), .aer_ack(ack_d),
    .fifo_data(data_d), .fifo_push(push_d), .fifo_full(full_d)
`ifdef DVS_AER_DROP_COUNT_EN
    , .drop_clr(drop_clr), .drop_count(dc_d)
`endif
  );

  dvs_aer_rx #(.DROP_ON_FULL(0)) u_stall (
    .clk(clk), .rst_n(rst_n), .enable(enable), .aer_req(req_st),
    .aer_x(aer_x), .aer_y(aer_y), .aer_pol(aer_pol), .aer_ack(ack_s),
    .fifo_data(data_s), .fifo_push(push_s), .fifo_full(full_s)
`ifdef DVS_AER_DROP_COUNT_EN
    , .drop_clr(1'b0), .drop_count(dc_s)
`endif
  );

  // Record every push of the drop instance.
  always @(negedge clk) begin
    if (push_d === 1'b1) begin
      pcount++;
      pushq.push_back(data_d);
    end
  end

  // Full 4-phase handshake on the drop instance with bounded waits.
  task automatic send_event(input logic [7:0] x, input logic [7:0] y, input logic p,
                            input int d0, input int d1, output bit ok);
    int n;
    ok = 1'b1;
    repeat (d0) @(negedge clk);
    @(negedge clk);
    aer_x = x; aer_y = y; aer_pol = p; req_d = 1'b1;
    n = 0;
    while (ack_d !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (ack_d !== 1'b1) ok = 1'b0;
    repeat (d1) @(negedge clk);
    req_d = 1'b0;
    n = 0;
    while (ack_d !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    if (ack_d !== 1'b0) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++; if (ack_d !== 1'b0) begin fails++; $display("FAIL reset_ack got %b want 0", ack_d); end
    tests++; if (push_d !== 1'b0) begin fails++; $display("FAIL reset_push got %b want 0", push_d); end
    tests++; if (data_d !== 17'h0) begin fails++; $display("FAIL reset_data got %h want 0", data_d); end
    tests++; if (ack_s !== 1'b0 || push_s !== 1'b0 || data_s !== 17'h0) begin
      fails++; $display("FAIL reset_stall ack=%b push=%b data=%h want 0/0/0", ack_s, push_s, data_s);
    end
`ifdef DVS_AER_DROP_COUNT_EN
    tests++; if (dc_d !== 16'h0) begin fails++; $display("FAIL reset_dropcnt got %0d want 0", dc_d); end
`endif
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_single();
    int n0;
    n0 = pcount;
    @(negedge clk);
    aer_x = 8'h12; aer_y = 8'h34; aer_pol = 1'b1; req_d = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (push_d !== 1'b0 || ack_d !== 1'b0) begin
      fails++; $display("FAIL single_early push=%b ack=%b want 0/0", push_d, ack_d);
    end
    @(posedge clk); #1;
    tests++; if (push_d !== 1'b1) begin fails++; $display("FAIL single_push_edge3 got %b want 1", push_d); end
    tests++; if (data_d !== 17'h13412) begin fails++; $display("FAIL single_data got %h want 13412", data_d); end
    @(posedge clk); #1;
    tests++; if (ack_d !== 1'b1 || push_d !== 1'b0) begin
      fails++; $display("FAIL single_ack_edge4 ack=%b push=%b want 1/0", ack_d, push_d);
    end
    @(negedge clk); req_d = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++; if (ack_d !== 1'b1) begin fails++; $display("FAIL single_ack_hold got %b want 1", ack_d); end
    @(posedge clk); #1;
    tests++; if (ack_d !== 1'b0) begin fails++; $display("FAIL single_ack_fall got %b want 0", ack_d); end
    @(negedge clk); #1;
    tests++; if (pcount - n0 !== 1) begin fails++; $display("FAIL single_count got %0d want 1", pcount - n0); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] exp[$];
    logic [7:0] x, y;
    logic p;
    bit ok, all_ok;
    int bad;
    pushq.delete();
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = 8'(i * 17 + 3);
      y = 8'(8'hA0 ^ i);
      p = i[0];
      exp.push_back({p, y, x});
      send_event(x, y, p, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), ok);
      if (!ok) all_ok = 1'b0;
    end
    repeat (3) @(negedge clk);
    tests++; if (!all_ok) begin fails++; $display("FAIL b2b_handshake got timeout want none"); end
    tests++; if (pushq.size() !== 16) begin
      fails++; $display("FAIL b2b_count got %0d want 16", pushq.size());
    end
    bad = 0;
    for (int i = 0; i < 16 && i < pushq.size(); i++) begin
      if (pushq[i] !== exp[i]) begin
        bad++;
        $display("FAIL b2b_data[%0d] got %h want %h", i, pushq[i], exp[i]);
      end
    end
    tests++; if (bad != 0) fails++;
  endtask

  task automatic test_drop();
    int n0;
    bit ok, all_ok;
    all_ok = 1'b1;
    n0 = pcount;
    full_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_event(8'(i), 8'(i + 1), 1'b0, 1, 1, ok);
      if (!ok) all_ok = 1'b0;
    end
    repeat (3) @(negedge clk);
    tests++; if (!all_ok) begin fails++; $display("FAIL drop_acks got timeout want 3 acks"); end
    tests++; if (pcount - n0 !== 0) begin fails++; $display("FAIL drop_pushes got %0d want 0", pcount - n0); end
`ifdef DVS_AER_DROP_COUNT_EN
    tests++; if (dc_d !== 16'd3) begin fails++; $display("FAIL drop_count got %0d want 3", dc_d); end
    drop_clr = 1'b1;
    @(negedge clk); drop_clr = 1'b0;
    tests++; if (dc_d !== 16'd0) begin fails++; $display("FAIL drop_clr got %0d want 0", dc_d); end
`endif
    full_d = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    bit bad;
    bad = 1'b0;
    @(negedge clk);
    aer_x = 8'h5A; aer_y = 8'hC3; aer_pol = 1'b0; full_s = 1'b1; req_st = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (ack_s !== 1'b0 || push_s !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL stall_hold got ack/push activity want none"); end
    tests++; if (u_stall.state_q !== 4'b0010) begin
      fails++; $display("FAIL stall_state got %b want 0010", u_stall.state_q);
    end
    full_s = 1'b0;
    @(negedge clk);
    tests++; if (push_s !== 1'b1 || data_s !== 17'h0C35A) begin
      fails++; $display("FAIL stall_push push=%b data=%h want 1/0c35a", push_s, data_s);
    end
    @(negedge clk);
    tests++; if (ack_s !== 1'b1 || push_s !== 1'b0) begin
      fails++; $display("FAIL stall_ack ack=%b push=%b want 1/0", ack_s, push_s);
    end
    req_st = 1'b0;
    n = 0;
    while (ack_s !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    tests++; if (ack_s !== 1'b0) begin fails++; $display("FAIL stall_release got %b want 0", ack_s); end
  endtask

  task automatic test_reset_mid();
    int n, n0;
    bit bad, ok;
    @(negedge clk);
    aer_x = 8'h77; aer_y = 8'h11; aer_pol = 1'b1; req_d = 1'b1;
    n = 0;
    while (ack_d !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    tests++; if (ack_d !== 1'b1) begin fails++; $display("FAIL rstmid_ack got %b want 1", ack_d); end
    #1; n0 = pcount;
    #1 rst_n = 1'b0;
    #1;
    tests++; if (ack_d !== 1'b0) begin fails++; $display("FAIL rstmid_async_ack got %b want 0", ack_d); end
    @(negedge clk); rst_n = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ack_d !== 1'b0 || push_d !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL rstmid_held got ack/push activity want none"); end
    req_d = 1'b0;
    repeat (5) @(negedge clk);
    send_event(8'h21, 8'h43, 1'b0, 0, 2, ok);
    repeat (2) @(negedge clk);
    tests++; if (!ok || pcount - n0 !== 1 || pushq[pushq.size()-1] !== 17'h04321) begin
      fails++; $display("FAIL rstmid_new ok=%b pushes=%0d want 1 with data 04321", ok, pcount - n0);
    end
  endtask

  task automatic test_enable();
    int n;
    bit bad, seen;
    bad = 1'b0;
    seen = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    aer_x = 8'h0F; aer_y = 8'hF0; aer_pol = 1'b1; req_d = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (ack_d !== 1'b0 || push_d !== 1'b0) bad = 1'b1;
    end
    tests++; if (bad) begin fails++; $display("FAIL enable_low got ack/push activity want none"); end
    enable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (push_d === 1'b1 && data_d === 17'h1F00F) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL enable_push got none want push of 1f00f"); end
    n = 0;
    while (ack_d !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    req_d = 1'b0;
    n = 0;
    while (ack_d !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    tests++; if (ack_d !== 1'b0) begin fails++; $display("FAIL enable_release got %b want 0", ack_d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drop();
    test_stall();
    test_reset_mid();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
